// File: rtl/spm_operand_serializer_if.sv
// ---------------------------------------------------------------------------
// spm_operand_serializer_if
// Bundles the parallel operand handshake and the serial output stream of
// spm_operand_serializer.
//   master : drives in_valid / in_data / flush, observes everything else
//   slave  : the serializer itself
// Signals:
//   in_valid, in_ready, in_data[WIDTH] : parallel operand handshake
//   flush                              : synchronous abort of the current word
//   seq_clr_n                          : active-low clear for downstream flops
//   serial_out, serial_val             : LSB-first serial bit and its qualifier
//   first, last                        : stream delimiters (bit 0 / final bit)
//   sign                               : MSB of the last accepted operand
//   done                               : one-cycle pulse after the final bit
// ---------------------------------------------------------------------------
interface spm_operand_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             seq_clr_n;
    logic             serial_out;
    logic             serial_val;
    logic             first;
    logic             last;
    logic             sign;
    logic             done;

    modport master (
        output in_valid, in_data, flush,
        input  in_ready, seq_clr_n, serial_out, serial_val, first, last, sign, done
    );

    modport slave (
        input  in_valid, in_data, flush,
        output in_ready, seq_clr_n, serial_out, serial_val, first, last, sign, done
    );
endinterface

// File: rtl/spm_operand_serializer.sv
// ---------------------------------------------------------------------------
// spm_operand_serializer
// Feeds the bit-serial two's-complement negator of the SPM datapath. Takes a
// signed WIDTH-bit operand over valid/ready, pulses seq_clr_n low for one
// cycle so the downstream serial stage starts from zero, then emits the
// operand LSB-first, sign-extended to OUT_LEN bits, one bit per clk.
// Ports:
//   clk  : clock, all state changes on posedge
//   rst  : synchronous reset, active-high (also gates the outputs idle)
//   bus  : spm_operand_serializer_if.slave (handshake, flush, serial stream)
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a word, in_ready=1
// S_LOAD  | word captured, seq_clr_n=0 for this single cycle
// S_SHIFT | streaming shreg[0], one bit per cycle, OUT_LEN cycles
// ---------------------------------------------------------------------------
module spm_operand_serializer #(
    parameter int WIDTH   = 8,
    parameter int OUT_LEN = 16
) (
    input logic                           clk,
    input logic                           rst,
    spm_operand_serializer_if.slave       bus
);
    localparam int CNT_W = $clog2(OUT_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t             state;
    logic [OUT_LEN-1:0] shreg;
    logic [CNT_W-1:0]   count;
    logic               sign_q;
    logic               done_q;
    logic               cnt_last;

    assign cnt_last = (count == CNT_W'(OUT_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            shreg  <= '0;
            count  <= '0;
            sign_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // flush only matters while a word is in flight; in IDLE it just
            // blocks acceptance (handled in the S_IDLE branch)
            if (bus.flush && state != S_IDLE) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.in_valid && !bus.flush) begin
                            // signed size cast replicates the MSB up to OUT_LEN
                            shreg  <= OUT_LEN'($signed(bus.in_data));
                            sign_q <= bus.in_data[WIDTH-1];
                            state  <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        count <= '0;
                        state <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        shreg <= {shreg[OUT_LEN-1], shreg[OUT_LEN-1:1]};
                        if (cnt_last) begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Stream outputs are decoded from state; rst forces them to their idle
    // values immediately rather than waiting for the reset edge.
    always_comb begin
        bus.in_ready   = !rst && (state == S_IDLE);
        bus.seq_clr_n  = rst || (state != S_LOAD);
        bus.serial_val = !rst && (state == S_SHIFT);
        bus.serial_out = bus.serial_val && shreg[0];
        bus.first      = bus.serial_val && (count == '0);
        bus.last       = bus.serial_val && cnt_last;
        bus.sign       = sign_q;
        bus.done       = done_q;
    end
endmodule

// File: tb/tb_spm_operand_serializer.sv
module tb_spm_operand_serializer;
    localparam int WIDTH   = 8;
    localparam int OUT_LEN = 16;

    typedef struct {
        logic b;
        logic f;
        logic l;
        int   cyc;
    } beat_t;

    logic clk;
    logic rst;

    spm_operand_serializer_if #(.WIDTH(WIDTH)) bus ();

    spm_operand_serializer #(.WIDTH(WIDTH), .OUT_LEN(OUT_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // reference model state
    int    cyc        = 0;
    int    busy_until = 0;
    int    clr_cycle  = -1;
    logic  sign_exp   = 1'b0;
    bit    chk_en     = 1'b0;
    beat_t bit_q[$];
    int    exp_done_q[$];
    int    acc_q[$];

    // words reassembled from the serial stream
    logic [OUT_LEN-1:0] got_words[$];
    logic [OUT_LEN-1:0] wacc;
    int                 widx;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: one word in flight at most; an accepted word at cycle T
    // produces bits at T+2..T+OUT_LEN+1 and done at T+OUT_LEN+2.
    always @(posedge clk) begin
        cyc = cyc + 1;
        chk_en = 1'b1;
        if (rst) begin
            bit_q.delete();
            exp_done_q.delete();
            busy_until = cyc;
            clr_cycle  = -1;
            sign_exp   = 1'b0;
        end else if (bus.flush) begin
            if (cyc - 1 < busy_until) begin
                bit_q.delete();
                exp_done_q.delete();
                busy_until = cyc;
            end
        end else if (bus.in_valid && (cyc - 1 >= busy_until)) begin
            int    t;
            int    sx;
            beat_t bt;
            t  = cyc - 1;
            sx = int'($signed(bus.in_data));
            for (int i = 0; i < OUT_LEN; i++) begin
                bt.b   = logic'((sx >>> i) & 1);
                bt.f   = (i == 0);
                bt.l   = (i == OUT_LEN - 1);
                bt.cyc = t + 2 + i;
                bit_q.push_back(bt);
            end
            exp_done_q.push_back(t + OUT_LEN + 2);
            busy_until = t + OUT_LEN + 2;
            clr_cycle  = t + 1;
            sign_exp   = (sx < 0);
            acc_q.push_back(t);
        end
    end

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", int'(bus.in_ready), int'(!rst && cyc >= busy_until));
            chk("seq_clr_n", int'(bus.seq_clr_n), int'(!(!rst && cyc == clr_cycle)));
            chk("sign", int'(bus.sign), int'(sign_exp));

            if (bus.serial_val || (bit_q.size() > 0 && bit_q[0].cyc <= cyc)) begin
                chk("serial_val", int'(bus.serial_val), 1);
                chk("beat_expected", int'(bit_q.size() > 0), 1);
                if (bit_q.size() > 0) begin
                    beat_t e;
                    e = bit_q.pop_front();
                    chk("beat_cycle", cyc, e.cyc);
                    chk("serial_out", int'(bus.serial_out), int'(e.b));
                    chk("first", int'(bus.first), int'(e.f));
                    chk("last", int'(bus.last), int'(e.l));
                end
                if (bus.serial_val) begin
                    if (bus.first) begin
                        wacc = '0;
                        widx = 0;
                    end
                    if (widx < OUT_LEN) wacc[widx] = bus.serial_out;
                    widx++;
                    if (bus.last) got_words.push_back(wacc);
                end
            end else begin
                chk("quiet_stream", int'({bus.serial_out, bus.first, bus.last}), 0);
            end

            if (bus.done || (exp_done_q.size() > 0 && exp_done_q[0] <= cyc)) begin
                chk("done", int'(bus.done), 1);
                chk("done_expected", int'(exp_done_q.size() > 0), 1);
                if (exp_done_q.size() > 0) chk("done_cycle", cyc, exp_done_q.pop_front());
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            step();
            n++;
        end
        chk("send_timeout", int'(n < 100), 1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            step();
            n++;
        end
        chk("idle_timeout", int'(n < 100), 1);
    endtask

    task automatic chk_word(input string name, input logic [OUT_LEN-1:0] exp);
        chk({name, "_present"}, int'(got_words.size() > 0), 1);
        if (got_words.size() > 0) chk(name, int'(got_words[$]), int'(exp));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

    initial begin
        logic [OUT_LEN-1:0] neg;
        int                 gap;

        // T1: reset held with in_valid asserted
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        bus.flush    = 1'b0;
        repeat (3) step();
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        step();

        // T2: positive operand
        send(8'h05);
        wait_idle();
        chk_word("t2_word", 16'h0005);

        // T3: negative operand, negation reconstructs +125
        send(8'h83);
        wait_idle();
        chk_word("t3_word", 16'hFF83);
        if (got_words.size() > 0) begin
            neg = -got_words[$];
            chk("t3_negated", int'(neg), 16'h007D);
        end

        // T4: back-to-back, second word taken in the done cycle
        step();
        send(8'h7F);
        send(8'h80);
        wait_idle();
        chk("t4_spacing", acc_q[$] - acc_q[$-1], OUT_LEN + 2);
        chk_word("t4_word2", 16'hFF80);

        // T5: flush at count=5, then a normal word
        send(8'h3C);
        repeat (6) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("t5_idle_after_flush", int'(bus.in_ready), 1);
        send(8'h01);
        wait_idle();
        chk_word("t5_word", 16'h0001);

        // flush together with in_valid in IDLE: nothing accepted
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("flush_blocks_accept", int'(bus.in_ready), 1);

        // T6: in_valid pulsed mid-stream is ignored
        send(8'hA6);
        repeat (4) step();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        repeat (3) step();
        bus.in_valid = 1'b0;
        wait_idle();
        chk_word("t6_word", 16'hFFA6);

        // reset mid-stream: no done follows
        send(8'h5A);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // randomized traffic with occasional flushes
        for (int k = 0; k < 30; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) step();
            send(WIDTH'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 17)) step();
                bus.flush = 1'b1;
                step();
                bus.flush = 1'b0;
            end
        end
        wait_idle();
        repeat (3) step();

        chk("beats_drained", bit_q.size(), 0);
        chk("dones_drained", exp_done_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
